// File: rtl/csr_file.sv
// Machine-mode CSR file: mstatus/mtvec/mscratch/mepc/mcause, 64-bit cycle/instret counters, trap save/restore.
// Latency: reads are combinational from pre-edge state; writes, traps and counter updates land on the next rising edge.
// Backpressure: none; every access resolves in its own cycle, and illegal accesses are flagged instead of stalled.
module csr_file (
   input  logic        clk,
   input  logic        reset,
   input  logic        csr_en,
   input  logic [1:0]  csr_op,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        illegal_csr,
   input  logic        save_exp,
   input  logic [3:0]  exp_code,
   input  logic [31:0] exp_pc,
   input  logic        restore_exp,
   output logic [31:0] mepc_o,
   output logic [31:0] mtvec_o,
   output logic        mie_o,
   input  logic        insn_retire
);

   localparam logic [1:0]  OP_RW       = 2'b01;
   localparam logic [1:0]  OP_RS       = 2'b10;
   localparam logic [1:0]  OP_RC       = 2'b11;

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_CYCLE     = 12'hC00;
   localparam logic [11:0] A_CYCLEH    = 12'hC80;
   localparam logic [11:0] A_INSTRET   = 12'hC02;
   localparam logic [11:0] A_INSTRETH  = 12'hC82;

   // Architectural state; mtvec/mepc keep bits 1:0 forced to zero on every load
   logic        r_mie;
   logic        r_mpie;
   logic [31:0] r_mtvec;
   logic [31:0] r_mscratch;
   logic [31:0] r_mepc;
   logic [3:0]  r_mcause;
   logic [63:0] r_mcycle;
   logic [63:0] r_minstret;

   logic        w_impl;
   logic [31:0] w_old;
   logic [31:0] w_new;
   logic        w_wr_req;
   logic        w_ro;
   logic        w_we;
   logic [63:0] w_mcycle_nxt;
   logic [63:0] w_minstret_nxt;

   // Address decode and old-value mux; unknown addresses read 0 and are flagged unimplemented
   always_comb begin
      w_impl = 1'b1;
      w_old  = 32'd0;
      case (csr_addr)
         A_MSTATUS:              w_old = {24'd0, r_mpie, 3'd0, r_mie, 3'd0};
         A_MTVEC:                w_old = r_mtvec;
         A_MSCRATCH:             w_old = r_mscratch;
         A_MEPC:                 w_old = r_mepc;
         A_MCAUSE:               w_old = {28'd0, r_mcause};
         A_MCYCLE,   A_CYCLE:    w_old = r_mcycle[31:0];
         A_MCYCLEH,  A_CYCLEH:   w_old = r_mcycle[63:32];
         A_MINSTRET, A_INSTRET:  w_old = r_minstret[31:0];
         A_MINSTRETH, A_INSTRETH: w_old = r_minstret[63:32];
         default:                w_impl = 1'b0;
      endcase
   end

   // Read-modify-write result for the three access types
   always_comb begin
      w_new = csr_wdata;
      case (csr_op)
         OP_RS:   w_new = w_old | csr_wdata;
         OP_RC:   w_new = w_old & ~csr_wdata;
         default: w_new = csr_wdata;
      endcase
   end

   // RS/RC with a zero operand is a pure read, so it is legal even on the read-only aliases
   assign w_wr_req    = csr_en & ((csr_op == OP_RW) | (csr_op[1] & (csr_wdata != 32'd0)));
   assign w_ro        = (csr_addr[11:8] == 4'hC);
   assign illegal_csr = csr_en & (~w_impl | (w_wr_req & w_ro));
   assign csr_rdata   = illegal_csr ? 32'd0 : w_old;
   // Trap save/restore take the edge; a CSR write in the same cycle is dropped
   assign w_we        = w_wr_req & ~illegal_csr & ~save_exp & ~restore_exp;

   assign mepc_o  = r_mepc;
   assign mtvec_o = r_mtvec;
   assign mie_o   = r_mie;

   // Counter next values: a written half replaces the increment and the other half holds
   always_comb begin
      w_mcycle_nxt   = r_mcycle + 64'd1;
      w_minstret_nxt = r_minstret + {63'd0, insn_retire};
      if (w_we && csr_addr == A_MCYCLE)
         w_mcycle_nxt = {r_mcycle[63:32], w_new};
      else if (w_we && csr_addr == A_MCYCLEH)
         w_mcycle_nxt = {w_new, r_mcycle[31:0]};
      if (w_we && csr_addr == A_MINSTRET)
         w_minstret_nxt = {r_minstret[63:32], w_new};
      else if (w_we && csr_addr == A_MINSTRETH)
         w_minstret_nxt = {w_new, r_minstret[31:0]};
   end

   // Counter registers; reset overrides both increment and write
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mcycle   <= 64'd0;
         r_minstret <= 64'd0;
      end else begin
         r_mcycle   <= w_mcycle_nxt;
         r_minstret <= w_minstret_nxt;
      end
   end

   // Control CSRs with priority reset > trap save > trap restore > CSR write
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mie      <= 1'b0;
         r_mpie     <= 1'b0;
         r_mtvec    <= 32'd0;
         r_mscratch <= 32'd0;
         r_mepc     <= 32'd0;
         r_mcause   <= 4'd0;
      end else if (save_exp) begin
         r_mepc     <= exp_pc & 32'hFFFF_FFFC;
         r_mcause   <= exp_code;
         r_mpie     <= r_mie;
         r_mie      <= 1'b0;
      end else if (restore_exp) begin
         r_mie      <= r_mpie;
         r_mpie     <= 1'b1;
      end else if (w_we) begin
         case (csr_addr)
            A_MSTATUS: begin
               r_mie  <= w_new[3];
               r_mpie <= w_new[7];
            end
            A_MTVEC:    r_mtvec    <= w_new & 32'hFFFF_FFFC;
            A_MSCRATCH: r_mscratch <= w_new;
            A_MEPC:     r_mepc     <= w_new & 32'hFFFF_FFFC;
            A_MCAUSE:   r_mcause   <= w_new[3:0];
            default:    ;
         endcase
      end
   end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit, reset that is synchronous and active-high.
REQ-003 The block SHALL have the port csr_en, input, 1 bit, CSR instruction valid this cycle.
REQ-004 The block SHALL have the port csr_op, input, 2 bits, access type: 00 none, 01 RW, 10 RS (set), 11 RC (clear).
REQ-005 The block SHALL have the port csr_addr, input, 12 bits, CSR address.
REQ-006 The block SHALL have the port csr_wdata, input, 32 bits, operand (rs1 value or zimm).
REQ-007 The block SHALL have the port csr_rdata, output, 32 bits, old value of the addressed CSR (combinational).
REQ-008 The block SHALL have the port illegal_csr, output, 1 bit, access to an unimplemented CSR or a write to a read-only CSR.
REQ-009 The block SHALL have the port save_exp, input, 1 bit, exception commit request from the main controller.
REQ-010 The block SHALL have the port exp_code, input, 4 bits, exception cause, valid with save_exp.
REQ-011 The block SHALL have the port exp_pc, input, 32 bits, PC of the faulting instruction, valid with save_exp.
REQ-012 The block SHALL have the port restore_exp, input, 1 bit, eret commit request from the main controller.
REQ-013 The block SHALL have the port mepc_o, output, 32 bits, current mepc value, returned to the main controller as the eret target.
REQ-014 The block SHALL have the port mtvec_o, output, 32 bits, current mtvec value.
REQ-015 The block SHALL have the port mie_o, output, 1 bit, mstatus.MIE.
REQ-016 The block SHALL have the port insn_retire, input, 1 bit, one instruction retired this cycle.

Function
REQ-017 The block SHALL implement the following CSRs:
- mstatus at 0x300: only bit 3 (MIE) and bit 7 (MPIE) are writable; all other bits read 0.
- mtvec at 0x305: bits 1:0 read 0.
- mscratch at 0x340.
- mepc at 0x341: bits 1:0 read 0.
- mcause at 0x342: bits 3:0 hold the code; all other bits read 0.
- Counters: mcycle at 0xB00, mcycleh at 0xB80, minstret at 0xB02, minstreth at 0xB82.
- Read-only aliases: cycle at 0xC00, cycleh at 0xC80, instret at 0xC02, instreth at 0xC82.
REQ-018 The new value on a write SHALL be:
- RW: wdata.
- RS: old | wdata.
- RC: old & ~wdata.
The result is written at the next clock edge when csr_en=1 and illegal_csr=0.
REQ-019 An RS or RC access with csr_wdata=0 SHALL be a read only: no write, and it is legal on read-only CSRs.
REQ-020 illegal_csr SHALL be 1 in either case below, and is 0 whenever csr_en=0:
- csr_en=1 and csr_addr is unimplemented.
- A write would occur to any address 0xC00-0xCFF.
On an illegal access csr_rdata is 0 and no state changes.
REQ-021 On save_exp=1 the next edge SHALL perform all of:
- mepc<=exp_pc with bits 1:0 cleared.
- mcause<=exp_code.
- MPIE<=MIE.
- MIE<=0.
REQ-022 On restore_exp=1 (and save_exp=0) the next edge SHALL perform MIE<=MPIE and MPIE<=1.
REQ-023 Priority SHALL be save_exp > restore_exp > CSR write; a CSR write in the same cycle as save_exp or restore_exp is discarded.
REQ-024 mcycle/mcycleh SHALL form a 64-bit counter that increments by 1 every cycle not in reset and wraps from 2^64-1 to 0.
REQ-025 A write to mcycle or mcycleh SHALL load the written half; that cycle, the written value replaces the increment for that half, and the other half keeps its value.
REQ-026 minstret/minstreth SHALL behave as in REQ-024/REQ-025, but increment only on insn_retire=1.
REQ-027 csr_rdata, mepc_o, mtvec_o and mie_o SHALL reflect register values before the current edge: no write-through bypass, one-cycle write-to-read latency.

Reset
REQ-028 When reset=1 at an edge, all CSRs, including the counters, SHALL clear to 0, so mepc_o, mtvec_o and mie_o read 0.
REQ-029 Reset SHALL override save_exp, restore_exp, CSR writes and counter increments in the same cycle.

Verification
REQ-030 The bench SHALL cover: RW 0x341 wdata 0x0000_1003 -> next cycle mepc_o=0x0000_1000 and csr_rdata@0x341=0x0000_1000.
REQ-031 The bench SHALL cover: MIE=1, save_exp=1, exp_code=4'h2, exp_pc=0x80 -> mepc=0x80, mcause=2, MIE=0, MPIE=1; then restore_exp=1 -> MIE=1, MPIE=1.
REQ-032 The bench SHALL cover: save_exp=1, restore_exp=1 and an RW to mscratch in the same cycle -> only the save is applied and mscratch is unchanged.
REQ-033 The bench SHALL cover: RW 0xC00 -> illegal_csr=1 with no state change; RS 0xC00 with wdata 0 -> illegal_csr=0 and the cycle count is read.
REQ-034 The bench SHALL cover: write mcycle=0xFFFF_FFFF and mcycleh=0xFFFF_FFFF -> after 1 cycle both halves read 0 (wrap).
REQ-035 The bench SHALL cover: reset asserted mid-count with save_exp=1 -> all outputs 0 next cycle; mcycle=1 one cycle after reset deasserts.
